// File: rtl/pwr_phase_ctrl.sv
// Phase-angle firing controller: SPI-loaded shadow setpoints, copied to active on each SYNC edge.
// Define PWR_PHASE_WDOG_EN to compile in the sync-loss watchdog (trips when PC reaches MAXPER).
module pwr_phase_ctrl #(
  parameter int NCH    = 4,
  parameter int CW     = 16,
  parameter int PW     = 64,
  parameter int MAXPER = (1 << CW) - 1
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           SSEL,
  input  logic           SCK,
  input  logic           MOSI,
  output logic           MISO,
  input  logic           SYNC,
  output logic [NCH-1:0] BRN,
  output logic           STR,
  output logic           ERR
);

  localparam int FW   = 8 + CW;
  localparam int BCW  = $clog2(FW + 1);
  localparam int PWCW = $clog2(PW + 1);
  localparam logic [CW-1:0] PC_MAX = '1;

`ifdef PWR_PHASE_WDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} spi_state_t;

  spi_state_t     state;
  logic [2:0]     ssel_sr, sck_sr;
  logic [1:0]     mosi_sr;
  logic [BCW-1:0] bit_cnt;
  logic [FW-1:0]  frame_sr;
  logic [CW-1:0]  tx_sr;
  logic           overrun, frame_err;

  logic [CW-1:0]  sp_sh  [NCH];
  logic [CW-1:0]  sp_act [NCH];
  logic [NCH-1:0] mode_sh, mode_act;
  logic [PWCW-1:0] pw_cnt [NCH];
  logic [CW-1:0]  pc;
  logic           sync_q, wd_inh, wd_err;

  logic ssel_rise, ssel_fall, sck_rise, sck_fall, mosi_s;
  logic sync_rise, wd_hit, frame_ok;
  logic [6:0]    hdr_next;
  logic [7:0]    hdr_done;
  logic [CW-1:0] rd_val;

  assign ssel_rise = ssel_sr[1] & ~ssel_sr[2];
  assign ssel_fall = ~ssel_sr[1] & ssel_sr[2];
  assign sck_rise  = sck_sr[1] & ~sck_sr[2];
  assign sck_fall  = ~sck_sr[1] & sck_sr[2];
  assign mosi_s    = mosi_sr[1];

  // Header as it will look once the current (8th) header bit is shifted in.
  assign hdr_next = {frame_sr[5:0], mosi_s};
  assign hdr_done = frame_sr[FW-1:CW];
  assign frame_ok = ({1'b0, hdr_done[3:0]} < 5'(NCH)) && (hdr_done[6:5] == 2'b00);

  assign sync_rise = SYNC & ~sync_q;
  assign wd_hit    = WD_EN && (pc == CW'(MAXPER));
  assign ERR       = frame_err | wd_err;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NCH; i++) begin
      if (hdr_next[3:0] == 4'(i)) begin
        if (hdr_next[6:4] == 3'd0)      rd_val = sp_sh[i];
        else if (hdr_next[6:4] == 3'd1) rd_val = CW'(mode_sh[i]);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      // NOTE: SSEL sync resets low so a select still held low after reset never opens a frame.
      ssel_sr   <= '0;
      sck_sr    <= '0;
      mosi_sr   <= '0;
      state     <= IDLE;
      bit_cnt   <= '0;
      frame_sr  <= '0;
      tx_sr     <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      MISO      <= 1'b0;
      STR       <= 1'b1;
      mode_sh   <= '0;
      for (int i = 0; i < NCH; i++) sp_sh[i] <= PC_MAX;
    end else begin
      ssel_sr <= {ssel_sr[1:0], SSEL};
      sck_sr  <= {sck_sr[1:0], SCK};
      mosi_sr <= {mosi_sr[0], MOSI};
      STR     <= 1'b1;
      case (state)
        IDLE: if (ssel_fall) begin
          state   <= HDR;
          bit_cnt <= '0;
          overrun <= 1'b0;
        end
        HDR: if (ssel_rise) begin
          state     <= IDLE;
          frame_err <= 1'b1;
        end else if (sck_rise) begin
          frame_sr <= {frame_sr[FW-2:0], mosi_s};
          if (bit_cnt == BCW'(7)) begin
            state   <= DATA;
            bit_cnt <= '0;
            tx_sr   <= rd_val;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: if (ssel_rise) begin
          state     <= IDLE;
          frame_err <= 1'b1;
          MISO      <= 1'b0;
        end else if (sck_fall) begin
          MISO  <= tx_sr[CW-1];
          tx_sr <= tx_sr << 1;
        end else if (sck_rise) begin
          frame_sr <= {frame_sr[FW-2:0], mosi_s};
          if (bit_cnt == BCW'(CW - 1)) begin
            state <= DONE;
            MISO  <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DONE: if (ssel_rise) begin
          state <= IDLE;
          if (!overrun && frame_ok) begin
            STR <= 1'b0;
            if (!hdr_done[7]) begin
              for (int i = 0; i < NCH; i++) begin
                if (hdr_done[3:0] == 4'(i)) begin
                  if (hdr_done[4]) mode_sh[i] <= frame_sr[0];
                  else             sp_sh[i]   <= frame_sr[CW-1:0];
                end
              end
            end
          end else begin
            frame_err <= 1'b1;
          end
        end else if (sck_rise) begin
          overrun <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sync_q   <= 1'b0;
      pc       <= '0;
      BRN      <= '0;
      wd_inh   <= 1'b0;
      wd_err   <= 1'b0;
      mode_act <= '0;
      for (int i = 0; i < NCH; i++) begin
        sp_act[i] <= PC_MAX;
        pw_cnt[i] <= '0;
      end
    end else begin
      sync_q <= SYNC;
      if (sync_rise) begin
        // NOTE: non-blocking copy reads the pre-edge shadow, so a write landing this cycle waits a period.
        pc       <= '0;
        BRN      <= '0;
        wd_inh   <= 1'b0;
        mode_act <= mode_sh;
        for (int i = 0; i < NCH; i++) sp_act[i] <= sp_sh[i];
      end else begin
        if (pc != PC_MAX) pc <= pc + 1'b1;
        if (wd_hit) begin
          wd_inh <= 1'b1;
          wd_err <= 1'b1;
        end
        for (int i = 0; i < NCH; i++) begin
          if (wd_hit || wd_inh) begin
            BRN[i] <= 1'b0;
          end else if (pc == sp_act[i] && sp_act[i] != PC_MAX) begin
            BRN[i]    <= 1'b1;
            pw_cnt[i] <= PWCW'(PW - 1);
          end else if (BRN[i] && mode_act[i]) begin
            if (pw_cnt[i] == '0) BRN[i]    <= 1'b0;
            else                 pw_cnt[i] <= pw_cnt[i] - 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pwr_phase_ctrl.sv
// Directed bench for pwr_phase_ctrl: SPI frames, firing latency, pulse width, errors, watchdog.
`timescale 1ns/1ps
module tb_pwr_phase_ctrl;

  localparam int NCH    = 4;
  localparam int CW     = 16;
  localparam int PW     = 64;
  localparam int MAXPER = 1000;

  logic           CLK = 1'b0;
  logic           RST_N = 1'b0;
  logic           SSEL = 1'b1;
  logic           SCK = 1'b0;
  logic           MOSI = 1'b0;
  logic           SYNC = 1'b0;
  logic           MISO, STR, ERR;
  logic [NCH-1:0] BRN;

  int n_checks = 0;
  int n_pass   = 0;
  int str_lows = 0;

  pwr_phase_ctrl #(.NCH(NCH), .CW(CW), .PW(PW), .MAXPER(MAXPER)) dut (
    .CLK(CLK), .RST_N(RST_N), .SSEL(SSEL), .SCK(SCK), .MOSI(MOSI),
    .MISO(MISO), .SYNC(SYNC), .BRN(BRN), .STR(STR), .ERR(ERR)
  );

  always #5 CLK = ~CLK;
  always @(negedge CLK) if (!STR) str_lows++;

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish within 100000 cycles");
    $fatal(1, "timeout");
  end

  task automatic clks(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset;
    @(negedge CLK);
    RST_N = 1'b0; SSEL = 1'b1; SCK = 1'b0; MOSI = 1'b0; SYNC = 1'b0;
    clks(4);
    RST_N = 1'b1;
    clks(4);
  endtask

  task automatic sync_pulse;
    @(negedge CLK); SYNC = 1'b1;
    @(negedge CLK); SYNC = 1'b0;
  endtask

  // SCK half-period of 8 CLK; MISO sampled as the master would, on SCK rise.
  task automatic spi_frame(input int nbits, input logic [31:0] word, input bit sync_at_end,
                           output logic [31:0] rd);
    rd = '0;
    @(negedge CLK); SSEL = 1'b0;
    clks(8);
    for (int i = nbits - 1; i >= 0; i--) begin
      MOSI = word[i];
      clks(8);
      SCK = 1'b1;
      rd = {rd[30:0], MISO};
      clks(8);
      SCK = 1'b0;
    end
    clks(8);
    SSEL = 1'b1;
    if (sync_at_end) begin
      clks(2); SYNC = 1'b1;
      clks(1); SYNC = 1'b0;
    end else begin
      clks(8);
    end
  endtask

  task automatic watch(input int ch, input int ncyc, output int first_k, output int high_cnt,
                       output bit others_hi);
    first_k = -1; high_cnt = 0; others_hi = 1'b0;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge CLK);
      if (BRN[ch]) begin
        high_cnt++;
        if (first_k < 0) first_k = k;
      end
      for (int j = 0; j < NCH; j++) if (j != ch && BRN[j]) others_hi = 1'b1;
    end
  endtask

  task automatic test_reset;
    @(negedge CLK);
    RST_N = 1'b0; SYNC = 1'b1; SSEL = 1'b0;
    clks(3);
    n_checks++; if (BRN !== 4'b0000) $display("FAIL reset_brn: got %b want 0000", BRN); else n_pass++;
    n_checks++; if (STR !== 1'b1) $display("FAIL reset_str: got %b want 1", STR); else n_pass++;
    n_checks++; if (MISO !== 1'b0) $display("FAIL reset_miso: got %b want 0", MISO); else n_pass++;
    n_checks++; if (ERR !== 1'b0) $display("FAIL reset_err: got %b want 0", ERR); else n_pass++;
    SYNC = 1'b0; SSEL = 1'b1; RST_N = 1'b1;
    clks(10);
    n_checks++; if (ERR !== 1'b0) $display("FAIL reset_release_err: got %b want 0", ERR); else n_pass++;
  endtask

  task automatic test_fire_timing;
    logic [31:0] rd; int s0, first, hi; bit oth;
    do_reset;
    s0 = str_lows;
    spi_frame(24, 32'h020100, 1'b0, rd);
    n_checks++; if (str_lows - s0 !== 1) $display("FAIL write_str: got %0d low cycles want 1", str_lows - s0); else n_pass++;
    n_checks++; if (ERR !== 1'b0) $display("FAIL write_err: got %b want 0", ERR); else n_pass++;
    sync_pulse;
    watch(2, 300, first, hi, oth);
    n_checks++; if (first !== 257) $display("FAIL sp2_latency: got %0d want 257", first); else n_pass++;
    n_checks++; if (hi !== 44) $display("FAIL sp2_latched: got %0d high cycles want 44", hi); else n_pass++;
    n_checks++; if (oth !== 1'b0) $display("FAIL sp2_others: got %b want 0", oth); else n_pass++;
  endtask

  task automatic test_pulsed;
    logic [31:0] rd; int first, hi; bit oth;
    do_reset;
    spi_frame(24, 32'h110001, 1'b0, rd);
    spi_frame(24, 32'h010010, 1'b0, rd);
    sync_pulse;
    watch(1, 200, first, hi, oth);
    n_checks++; if (first !== 17) $display("FAIL pulse_latency: got %0d want 17", first); else n_pass++;
    n_checks++; if (hi !== PW) $display("FAIL pulse_width: got %0d want %0d", hi, PW); else n_pass++;
    spi_frame(24, 32'h110000, 1'b0, rd);
    sync_pulse;
    n_checks++; if (BRN !== 4'b0000) $display("FAIL sync_clears_brn: got %b want 0000", BRN); else n_pass++;
    watch(1, 200, first, hi, oth);
    n_checks++; if (first !== 17) $display("FAIL latch_latency: got %0d want 17", first); else n_pass++;
    n_checks++; if (hi !== 184) $display("FAIL latch_width: got %0d want 184", hi); else n_pass++;
  endtask

  task automatic test_shadow_readback;
    logic [31:0] rd; int first, hi; bit oth;
    do_reset;
    spi_frame(24, 32'h001234, 1'b0, rd);
    watch(0, 4700, first, hi, oth);
    n_checks++; if (hi !== 0) $display("FAIL shadow_not_active: got %0d high cycles want 0", hi); else n_pass++;
    spi_frame(24, 32'h800000, 1'b0, rd);
    n_checks++; if (rd[15:0] !== 16'h1234) $display("FAIL read_sp0: got %h want 1234", rd[15:0]); else n_pass++;
    spi_frame(24, 32'h830000, 1'b0, rd);
    n_checks++; if (rd[15:0] !== 16'hFFFF) $display("FAIL read_sp3: got %h want ffff", rd[15:0]); else n_pass++;
    spi_frame(24, 32'h920000, 1'b0, rd);
    n_checks++; if (rd[15:0] !== 16'h0000) $display("FAIL read_mode2: got %h want 0000", rd[15:0]); else n_pass++;
    n_checks++; if (MISO !== 1'b0) $display("FAIL miso_idle: got %b want 0", MISO); else n_pass++;
  endtask

  task automatic test_bad_frames;
    logic [31:0] rd; int s0;
    do_reset;
    s0 = str_lows;
    spi_frame(24, 32'h070042, 1'b0, rd);
    n_checks++; if (ERR !== 1'b1) $display("FAIL bad_ch_err: got %b want 1", ERR); else n_pass++;
    n_checks++; if (str_lows !== s0) $display("FAIL bad_ch_str: got %0d low cycles want 0", str_lows - s0); else n_pass++;
    spi_frame(24, 32'h830000, 1'b0, rd);
    n_checks++; if (rd[15:0] !== 16'hFFFF) $display("FAIL bad_ch_sp3: got %h want ffff", rd[15:0]); else n_pass++;
    do_reset;
    n_checks++; if (ERR !== 1'b0) $display("FAIL err_cleared: got %b want 0", ERR); else n_pass++;
    s0 = str_lows;
    spi_frame(20, 32'h000ABC, 1'b0, rd);
    n_checks++; if (ERR !== 1'b1) $display("FAIL short_err: got %b want 1", ERR); else n_pass++;
    n_checks++; if (str_lows !== s0) $display("FAIL short_str: got %0d low cycles want 0", str_lows - s0); else n_pass++;
    spi_frame(24, 32'h800000, 1'b0, rd);
    n_checks++; if (rd[15:0] !== 16'hFFFF) $display("FAIL short_sp0: got %h want ffff", rd[15:0]); else n_pass++;
    do_reset;
    s0 = str_lows;
    spi_frame(25, 32'h0000055, 1'b0, rd);
    n_checks++; if (ERR !== 1'b1) $display("FAIL long_err: got %b want 1", ERR); else n_pass++;
    n_checks++; if (str_lows !== s0) $display("FAIL long_str: got %0d low cycles want 0", str_lows - s0); else n_pass++;
  endtask

  task automatic test_back_to_back_sync;
    logic [31:0] rd; int first, hi; bit oth;
    do_reset;
    spi_frame(24, 32'h030020, 1'b1, rd);
    n_checks++; if (STR !== 1'b0) $display("FAIL coincide_str: got %b want 0", STR); else n_pass++;
    watch(3, 100, first, hi, oth);
    n_checks++; if (hi !== 0) $display("FAIL coincide_deferred: got %0d high cycles want 0", hi); else n_pass++;
    sync_pulse;
    watch(3, 100, first, hi, oth);
    n_checks++; if (first !== 33) $display("FAIL coincide_next: got %0d want 33", first); else n_pass++;
  endtask

  task automatic test_zero_sp;
    logic [31:0] rd;
    do_reset;
    spi_frame(24, 32'h000000, 1'b0, rd);
    sync_pulse;
    n_checks++; if (BRN !== 4'b0000) $display("FAIL zero_sp_k0: got %b want 0000", BRN); else n_pass++;
    @(negedge CLK);
    n_checks++; if (BRN !== 4'b0001) $display("FAIL zero_sp_k1: got %b want 0001", BRN); else n_pass++;
  endtask

  task automatic test_watchdog;
    logic [31:0] rd; int first, hi; bit oth;
    do_reset;
    spi_frame(24, 32'h000010, 1'b0, rd);
    sync_pulse;
    watch(0, MAXPER, first, hi, oth);
    n_checks++; if (first !== 17) $display("FAIL wd_fire: got %0d want 17", first); else n_pass++;
    n_checks++; if (ERR !== 1'b0) $display("FAIL wd_err_before: got %b want 0", ERR); else n_pass++;
    @(negedge CLK);
`ifdef PWR_PHASE_WDOG_EN
    n_checks++; if (ERR !== 1'b1) $display("FAIL wd_err_trip: got %b want 1", ERR); else n_pass++;
    n_checks++; if (BRN !== 4'b0000) $display("FAIL wd_brn_forced: got %b want 0000", BRN); else n_pass++;
    @(negedge CLK); RST_N = 1'b0;
    @(negedge CLK);
    n_checks++; if (ERR !== 1'b0) $display("FAIL wd_err_reset: got %b want 0", ERR); else n_pass++;
    RST_N = 1'b1;
`else
    n_checks++; if (ERR !== 1'b0) $display("FAIL nowd_err: got %b want 0", ERR); else n_pass++;
    n_checks++; if (BRN !== 4'b0001) $display("FAIL nowd_brn_held: got %b want 0001", BRN); else n_pass++;
`endif
  endtask

  initial begin
    test_reset;
    test_fire_timing;
    test_pulsed;
    test_shadow_readback;
    test_bad_frames;
    test_back_to_back_sync;
    test_zero_sp;
    test_watchdog;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
